// File: rtl/q_mult_pkg.sv
// q_mult_pkg: shared definitions for the serial-bus shift-add multiplier.
//   state_t      controller state (IDLE, LOAD, CALC, OUTPUT), 2-bit encoding
//   beats()      number of bus beats per operand
//   DEF_OP_W     default operand width
//   DEF_BUS_W    default bus width
package q_mult_pkg;

  localparam int DEF_OP_W  = 32;
  localparam int DEF_BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CALC   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  function automatic int beats(input int op_w, input int bus_w);
    return op_w / bus_w;
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: datapath of the serial shift-add multiplier.
// Holds the accumulator A, multiplicand B, multiplier Q and carry/sign bit C.
// Each step adds (or, for the final signed step, subtracts) B into {C,A}
// when Q[0] is set, then shifts {C,A,Q} right by one.
// Ports:
//   clk, rst_b     clock, asynchronous active-low reset
//   i_clear        operation accepted: clear A, C and Q
//   i_load_b       write beat i_beat_idx of B from i_m
//   i_load_q       write beat i_beat_idx of Q from i_m
//   i_beat_idx     operand beat index for loads
//   i_step         perform one add/shift step
//   i_last_step    this step is the multiplier's sign-bit step
//   i_signed       two's-complement operation
//   i_out_en       drive product beat on o_p (else o_p = 0)
//   i_out_sel      product beat index, 0 = Q[BUS_W-1:0]
//   i_m            input bus
//   o_p            product beat
module seq_mult_dp
  import q_mult_pkg::*;
#(
  parameter  int OP_W  = DEF_OP_W,
  parameter  int BUS_W = DEF_BUS_W,
  localparam int NB    = beats(OP_W, BUS_W),
  localparam int BIW   = $clog2(NB),
  localparam int OSW   = $clog2(2 * NB)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_clear,
  input  logic             i_load_b,
  input  logic             i_load_q,
  input  logic [BIW-1:0]   i_beat_idx,
  input  logic             i_step,
  input  logic             i_last_step,
  input  logic             i_signed,
  input  logic             i_out_en,
  input  logic [OSW-1:0]   i_out_sel,
  input  logic [BUS_W-1:0] i_m,
  output logic [BUS_W-1:0] o_p
);

  logic [OP_W-1:0]   r_a;
  logic [OP_W-1:0]   r_b;
  logic [OP_W-1:0]   r_q;
  logic              r_c;

  logic [OP_W:0]     w_ext_a;
  logic [OP_W:0]     w_ext_b;
  logic [OP_W:0]     w_sum;
  logic [2*OP_W-1:0] w_prod;

  // In signed mode r_c always equals A's sign, so {C,A} is A sign-extended;
  // in unsigned mode r_c is zero. The final signed step subtracts because
  // the multiplier's top bit carries weight -2^(OP_W-1).
  always_comb begin
    w_ext_a = {r_c, r_a};
    w_ext_b = {i_signed & r_b[OP_W-1], r_b};
    if (!r_q[0])
      w_sum = w_ext_a;
    else if (i_signed && i_last_step)
      w_sum = w_ext_a - w_ext_b;
    else
      w_sum = w_ext_a + w_ext_b;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_a <= '0;
      r_b <= '0;
      r_q <= '0;
      r_c <= 1'b0;
    end else begin
      if (i_clear) begin
        r_a <= '0;
        r_q <= '0;
        r_c <= 1'b0;
      end
      if (i_load_b) begin
        for (int i = 0; i < NB; i++)
          if (i_beat_idx == BIW'(i)) r_b[i*BUS_W +: BUS_W] <= i_m;
      end
      if (i_load_q) begin
        for (int i = 0; i < NB; i++)
          if (i_beat_idx == BIW'(i)) r_q[i*BUS_W +: BUS_W] <= i_m;
      end
      if (i_step) begin
        // Right shift of {C,A,Q}: arithmetic keeps the sign in C,
        // logical shifts a zero into C.
        r_c <= i_signed ? w_sum[OP_W] : 1'b0;
        r_a <= w_sum[OP_W:1];
        r_q <= {w_sum[0], r_q[OP_W-1:1]};
      end
    end
  end

  assign w_prod = {r_a, r_q};

  always_comb begin
    o_p = '0;
    if (i_out_en) begin
      for (int i = 0; i < 2 * NB; i++)
        if (i_out_sel == OSW'(i)) o_p = w_prod[i*BUS_W +: BUS_W];
    end
  end

endmodule

// File: rtl/seq_mult_bus.sv
// seq_mult_bus: serial-bus shift-add multiplier, unsigned or two's complement.
// Operands arrive least-significant beat first on M: multiplicand B, then
// multiplier Q (2*NB beats including the start beat). OP_W add/shift steps
// follow, then the 2*OP_W-bit product leaves on P, least-significant first.
//
// Handshake: start is taken only on an edge where rdy=1. A product beat
// transfers on an edge where send_output=1 and out_ready=1; while
// out_ready=0, P and send_output hold. Load beats carry no qualifier.
//
// Ports:
//   clk          clock, rising edge
//   rst_b        asynchronous active-low reset
//   start        operation request
//   signed_mode  sampled with an accepted start; 1 = two's complement
//   M            operand beats
//   out_ready    consumer accepts the current P beat
//   rdy          idle, ready for start
//   send_output  P carries a valid product beat
//   P            product beat
//   dbg_state    current controller state (state_t encoding)
module seq_mult_bus
  import q_mult_pkg::*;
#(
  parameter int OP_W  = DEF_OP_W,
  parameter int BUS_W = DEF_BUS_W
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [BUS_W-1:0] M,
  input  logic             out_ready,
  output logic             rdy,
  output logic             send_output,
  output logic [BUS_W-1:0] P,
  output logic [1:0]       dbg_state
);

  localparam int NB  = beats(OP_W, BUS_W);
  localparam int BIW = $clog2(NB);
  localparam int OSW = $clog2(2 * NB);
  localparam int CW  = $clog2(OP_W);

  if ((OP_W % BUS_W) != 0 || OP_W < 2 * BUS_W) begin : g_bad_width
    $error("seq_mult_bus: OP_W must be a multiple of BUS_W and at least 2*BUS_W");
  end

  state_t         r_state;
  logic           r_rdy;
  logic           r_send;
  logic           r_signed;
  logic [BIW-1:0] r_beat;      // operand beat index within B or Q
  logic           r_phase_q;   // 0 = loading B, 1 = loading Q
  logic [CW-1:0]  r_calc_cnt;
  logic [OSW-1:0] r_out_cnt;

  logic           w_accept;
  logic           w_load_b;
  logic           w_load_q;
  logic [BIW-1:0] w_beat_idx;
  logic           w_step;
  logic           w_last_step;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_load_b    = w_accept || ((r_state == LOAD) && !r_phase_q);
  assign w_load_q    = (r_state == LOAD) && r_phase_q;
  assign w_beat_idx  = w_accept ? '0 : r_beat;
  assign w_step      = (r_state == CALC);
  assign w_last_step = (r_calc_cnt == CW'(OP_W - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= IDLE;
      r_rdy      <= 1'b1;
      r_send     <= 1'b0;
      r_signed   <= 1'b0;
      r_beat     <= '0;
      r_phase_q  <= 1'b0;
      r_calc_cnt <= '0;
      r_out_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Beat 0 of B is captured on this edge.
            r_state    <= LOAD;
            r_rdy      <= 1'b0;
            r_signed   <= signed_mode;
            r_beat     <= BIW'(1);
            r_phase_q  <= 1'b0;
            r_calc_cnt <= '0;
            r_out_cnt  <= '0;
          end
        end
        LOAD: begin
          if (r_beat == BIW'(NB - 1)) begin
            r_beat <= '0;
            if (r_phase_q) r_state <= CALC;
            else           r_phase_q <= 1'b1;
          end else begin
            r_beat <= r_beat + BIW'(1);
          end
        end
        CALC: begin
          if (w_last_step) begin
            r_calc_cnt <= '0;
            r_state    <= OUTPUT;
            r_send     <= 1'b1;
            r_out_cnt  <= '0;
          end else begin
            r_calc_cnt <= r_calc_cnt + CW'(1);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (r_out_cnt == OSW'(2 * NB - 1)) begin
              r_state   <= IDLE;
              r_send    <= 1'b0;
              r_rdy     <= 1'b1;
              r_out_cnt <= '0;
            end else begin
              r_out_cnt <= r_out_cnt + OSW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  seq_mult_dp #(
    .OP_W  (OP_W),
    .BUS_W (BUS_W)
  ) u_dp (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_clear     (w_accept),
    .i_load_b    (w_load_b),
    .i_load_q    (w_load_q),
    .i_beat_idx  (w_beat_idx),
    .i_step      (w_step),
    .i_last_step (w_last_step),
    .i_signed    (r_signed),
    .i_out_en    (r_send),
    .i_out_sel   (r_out_cnt),
    .i_m         (M),
    .o_p         (P)
  );

  assign rdy         = r_rdy;
  assign send_output = r_send;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_mult_bus.sv
// tb_seq_mult_bus: bench for seq_mult_bus at 32/8 (dut0) and 16/4 (dut1).
// Expected products come from plain integer multiplication of the operands.
module tb_seq_mult_bus;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  // dut0: OP_W=32, BUS_W=8
  logic       start0, sm0, ordy0, rdy0, so0;
  logic [7:0] m0, p0;
  logic [1:0] dbg0;
  // dut1: OP_W=16, BUS_W=4
  logic       start1, sm1, ordy1, rdy1, so1;
  logic [3:0] m1, p1;
  logic [1:0] dbg1;

  seq_mult_bus #(.OP_W(32), .BUS_W(8)) dut0 (
    .clk(clk), .rst_b(rst_b), .start(start0), .signed_mode(sm0), .M(m0),
    .out_ready(ordy0), .rdy(rdy0), .send_output(so0), .P(p0), .dbg_state(dbg0)
  );

  seq_mult_bus #(.OP_W(16), .BUS_W(4)) dut1 (
    .clk(clk), .rst_b(rst_b), .start(start1), .signed_mode(sm1), .M(m1),
    .out_ready(ordy1), .rdy(rdy1), .send_output(so1), .P(p1), .dbg_state(dbg1)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input int sel, input logic st, input logic sm,
                       input logic [7:0] m, input logic ordy);
    if (sel == 0) begin
      start0 = st; sm0 = sm; m0 = m; ordy0 = ordy;
    end else begin
      start1 = st; sm1 = sm; m1 = m[3:0]; ordy1 = ordy;
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic get_so(input int sel);
    return (sel == 0) ? so0 : so1;
  endfunction

  function automatic logic [7:0] get_p(input int sel);
    return (sel == 0) ? p0 : {4'b0, p1};
  endfunction

  // Asynchronous reset between clock edges; outputs must drop at once.
  task automatic reset_pulse(input int sel);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_rdy", get_rdy(sel), 1'b1);
    chk("rst_so", get_so(sel), 1'b0);
    chk("rst_p", get_p(sel), 8'h00);
    @(negedge clk);
    chk("rst_hold_rdy", get_rdy(sel), 1'b1);
    rst_b = 1'b1;
    drive(sel, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  // One full operation. Called and returns at a negedge.
  //   bp_beat/bp_len : hold out_ready low bp_len cycles while beat bp_beat is shown
  //   poke_at        : edge number (start edge = 0) on which a stray start is driven
  //   rst_calc       : edge number before which reset is pulsed (CALC abort)
  //   rst_beat       : product beat during which reset is pulsed (OUTPUT abort)
  task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input int bp_beat, input int bp_len,
                       input int poke_at, input int rst_calc, input int rst_beat,
                       output logic [63:0] got);
    int          bw, opw, nb, n, j, stall, guard;
    logic        ordy;
    logic [63:0] ea, eb, ref_p, mask, opmask, bm;
    logic [7:0]  bmask, pv;
    logic [7:0]  exp_q[$];

    bw     = (sel == 0) ? 8 : 4;
    opw    = (sel == 0) ? 32 : 16;
    nb     = opw / bw;
    mask   = (sel == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    bmask  = (sel == 0) ? 8'hFF : 8'h0F;
    bm     = {56'b0, bmask};
    opmask = (64'd1 << opw) - 64'd1;
    got    = '0;

    // Reference: extend each operand per mode, multiply, keep 2*OP_W bits.
    ea = {32'b0, a} & opmask;
    eb = {32'b0, b} & opmask;
    if (sgn) begin
      if (ea[opw-1]) ea = ea | ~opmask;
      if (eb[opw-1]) eb = eb | ~opmask;
    end
    ref_p = (ea * eb) & mask;
    for (int i = 0; i < 2 * nb; i++)
      exp_q.push_back(8'((ref_p >> (i * bw)) & bm));

    // Load: start edge carries B beat 0, then B beats 1.., then Q beats.
    guard = 0;
    while (!get_rdy(sel) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("rdy_idle", get_rdy(sel), 1'b1);
    drive(sel, 1'b1, sgn, 8'(ea & bm), 1'b1);
    @(posedge clk);
    n = 1;
    for (int i = 1; i < 2 * nb; i++) begin
      @(negedge clk);
      if (i == 1) chk("rdy_drop", get_rdy(sel), 1'b0);
      if (i < nb) pv = 8'((ea >> (i * bw)) & bm);
      else        pv = 8'((eb >> ((i - nb) * bw)) & bm);
      // start and signed_mode toggles here must be ignored
      drive(sel, 1'($urandom_range(0, 1)), ~sgn, pv, 1'b1);
      @(posedge clk);
      n++;
    end

    // Calculation: wait for the first product beat.
    @(negedge clk);
    guard = 0;
    while (!get_so(sel) && guard < 100) begin
      if (n == rst_calc) begin
        reset_pulse(sel);
        return;
      end
      drive(sel, (n == poke_at), 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      @(posedge clk);
      n++;
      guard++;
      @(negedge clk);
    end
    chk("latency", 64'(n), 64'(2 * nb + opw));
    if (!get_so(sel)) begin
      drive(sel, 1'b0, 1'b0, 8'h00, 1'b1);
      return;
    end

    // Output: every presented beat must be the next expected one.
    j = 0; stall = 0; guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      chk("so_hi", get_so(sel), 1'b1);
      chk("rdy_lo", get_rdy(sel), 1'b0);
      chk($sformatf("beat%0d", j), get_p(sel), exp_q[0]);
      if (j == rst_beat) begin
        reset_pulse(sel);
        return;
      end
      ordy = !((j == bp_beat) && (stall < bp_len));
      if (!ordy) stall++;
      pv = get_p(sel);
      drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), ordy);
      @(posedge clk);
      if (ordy) begin
        got = got | ({56'b0, pv} << (j * bw));
        void'(exp_q.pop_front());
        j++;
      end
      @(negedge clk);
      guard++;
    end
    chk("beats_all", 64'(j), 64'(2 * nb));
    chk("done_so", get_so(sel), 1'b0);
    chk("done_rdy", get_rdy(sel), 1'b1);
    chk("done_p", get_p(sel), 8'h00);
    drive(sel, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] got;
    logic [31:0] a, b;
    int          sel, bpb, bpl;

    rst_b = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(1, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("reset_rdy0", rdy0, 1'b1);
    chk("reset_so0", so0, 1'b0);
    chk("reset_p0", p0, 8'h00);
    chk("reset_state0", dbg0, 2'd0);
    chk("reset_rdy1", rdy1, 1'b1);
    chk("reset_so1", so1, 1'b0);
    chk("reset_p1", p1, 4'h0);
    rst_b = 1'b1;
    @(negedge clk);

    // Directed, 32x8
    do_op(0, 32'h0000_00AA, 32'h0000_0002, 1'b0, -1, 0, -1, -1, -1, got);
    chk("dir_aa_x_2", got, 64'h0000_0000_0000_0154);
    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 0, -1, -1, -1, got);
    chk("dir_ff_u", got, 64'hFFFF_FFFE_0000_0001);
    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, 0, -1, -1, -1, got);
    chk("dir_ff_s", got, 64'h0000_0000_0000_0001);
    do_op(0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, -1, 0, -1, -1, -1, got);
    chk("dir_m2_x_3", got, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, -1, 0, -1, -1, -1, got);
    chk("dir_min_sq", got, 64'h4000_0000_0000_0000);

    // Backpressure on beat 2 for 3 cycles
    do_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 2, 3, -1, -1, -1, got);
    chk("dir_bp", got, 64'h0B00_EA4E_242D_2080);

    // Stray start at CALC cycle 20
    do_op(0, 32'h0000_1001, 32'h0000_0100, 1'b0, -1, 0, 8 + 20, -1, -1, got);
    chk("dir_poke", got, 64'h0000_0000_0010_0100);

    // Reset mid-CALC and mid-OUTPUT, each followed by a clean operation
    do_op(0, 32'hDEAD_BEEF, 32'h0000_0007, 1'b0, -1, 0, -1, 8 + 15, -1, got);
    do_op(0, 32'h0000_0007, 32'hFFFF_FFF9, 1'b1, -1, 0, -1, -1, -1, got);
    chk("post_rst_calc", got, 64'hFFFF_FFFF_FFFF_FFCF);
    do_op(0, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b0, -1, 0, -1, -1, 3, got);
    do_op(0, 32'h0000_0010, 32'h0000_0010, 1'b0, -1, 0, -1, -1, -1, got);
    chk("post_rst_out", got, 64'h0000_0000_0000_0100);

    // Directed, 16x4
    do_op(1, 32'h0000_1234, 32'h0000_0010, 1'b0, -1, 0, -1, -1, -1, got);
    chk("dir16_1234", got, 64'h0000_0000_0001_2340);
    do_op(1, 32'h0000_8000, 32'h0000_8000, 1'b1, -1, 0, -1, -1, -1, got);
    chk("dir16_min_sq", got, 64'h0000_0000_4000_0000);

    // Random against the reference model, both widths and both modes
    for (int v = 0; v < 400; v++) begin
      sel = v % 2;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h0;
        1: a = 32'hFFFF_FFFF;
        2: a = (sel == 0) ? 32'h8000_0000 : 32'h0000_8000;
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = (sel == 0) ? 32'h8000_0000 : 32'h0000_8000;
        default: ;
      endcase
      bpb = $urandom_range(0, 11);
      bpl = $urandom_range(1, 3);
      do_op(sel, a, b, 1'($urandom_range(0, 1)), bpb, bpl, -1, -1, -1, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded time limit, vectors %0d errors %0d", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_mult_bus.md
Name: seq_mult_bus

Overview:
- Parametrised successor to the team's 32-bit shift-add multiplier with an 8-bit bus.
- Multiplies two OP_W-bit operands delivered serially over a BUS_W-bit bus, using one add and one shift per cycle.
- Returns the 2*OP_W-bit product serially over the same-width output bus.
- New over the previous generation: generic widths, a signed (two's-complement) mode, and output backpressure via out_ready.

Parameters:
OP_W, 32, operand width in bits; must be a multiple of BUS_W and at least 2*BUS_W
BUS_W, 8, input/output bus width in bits
NB (localparam), OP_W/BUS_W, beats per operand; the product takes 2*NB beats

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_b  in  1  asynchronous, active-low reset
start  in  1  request; accepted only while rdy=1
signed_mode  in  1  sampled with an accepted start; 1 = both operands two's complement
M  in  BUS_W  operand beats, least-significant beat first: multiplicand B, then multiplier Q
out_ready  in  1  consumer accepts the current P beat
rdy  out  1  high in IDLE; block can accept start
send_output  out  1  P carries a valid product beat
P  out  BUS_W  product beat, least-significant first

Behaviour:
- Reset: asserting rst_b=0 forces IDLE immediately, at any time including mid-LOAD, mid-CALC or mid-OUTPUT.
  - Clears A, B, Q, C, all counters and the latched mode.
  - Outputs during and after reset: rdy=1, send_output=0, P=0.
  - No partial result is ever emitted after reset.
- States: IDLE -> LOAD -> CALC -> OUTPUT -> IDLE.
- IDLE:
  - rdy=1.
  - On an edge with start=1, the block captures M into B[BUS_W-1:0], latches signed_mode, clears A, C and the calc counter, and moves to LOAD.
  - rdy drops after that edge.
- LOAD:
  - M is captured on every edge with no valid qualifier: B beats 1..NB-1, then Q beats 0..NB-1.
  - Total load edges, including the start edge, is 2*NB.
  - After the last Q beat, the block moves to CALC.
  - start is ignored.
- CALC: exactly OP_W edges, counter 0..OP_W-1.
  - Unsigned step: if Q[0]=1 then {C,A} = A + B (OP_W+1-bit sum); then logical right shift of {C,A,Q} by 1, with C<=0.
  - Signed step: if Q[0]=1 then A = A + B (counter 0..OP_W-2) or A = A - B (counter = OP_W-1).
    - The sum is formed at OP_W+1 bits with sign extension, and C takes the true sign.
    - Then arithmetic right shift of {C,A,Q}; C keeps its sign.
  - After the final step, {A,Q} holds the 2*OP_W-bit product (unsigned or two's complement). The block moves to OUTPUT.
- OUTPUT:
  - send_output=1.
  - P = beat k of {A,Q}, with k from the beat counter, 0 = Q[BUS_W-1:0].
  - k advances only on an edge with out_ready=1; P and send_output hold stable while out_ready=0.
  - After beat 2*NB-1 is accepted, the block returns to IDLE: send_output=0, P=0, rdy=1 on the following cycle.
- Latency, start edge to first valid P, is 2*NB + OP_W cycles. For the default parameters that is 8 + 32 = 40; the output then takes 8 further cycles with out_ready held high.
- Back-to-back operation: start asserted in the first IDLE cycle is accepted. There is no bubble requirement beyond that one cycle.
- Edge cases:
  - start while rdy=0: no effect on state or data.
  - signed_mode changes outside the start edge: no effect.
  - out_ready=1 outside OUTPUT: ignored.
  - Signed -2^(OP_W-1) * -2^(OP_W-1) must give +2^(2*OP_W-2), with no overflow in the C bit.

Decomposition:
- Package q_mult_pkg holds:
  - the state enum (IDLE, LOAD, CALC, OUTPUT), 2-bit encoding;
  - function beats(op_w, bus_w);
  - default width constants.
- Sub-module seq_mult_dp is the natural split: the A/B/Q/C registers, the add/subtract, the shift, and the beat mux for P.
  - Controls come from the FSM in seq_mult_bus: load_b, load_q, step, last_step, signed latch, out_sel.
- Elaboration-time assertion that OP_W % BUS_W == 0.

Test Plan:
- Defaults, unsigned. M beats AA,00,00,00 then 02,00,00,00. Expect P = 54,01,00,00,00,00,00,00; first send_output 40 cycles after the start edge.
- Unsigned FF×8 beats -> P = 01,00,00,00,FE,FF,FF,FF. Same stimulus with signed_mode=1 (-1 × -1) -> P = 01,00,00,00,00,00,00,00.
- Signed 0xFFFFFFFE × 0x00000003 -> product 0xFFFFFFFF_FFFFFFFA. Signed 0x80000000 × 0x80000000 -> 0x40000000_00000000.
- Backpressure: drop out_ready for 3 cycles while beat 2 is presented. P and send_output must hold stable, no beat may be skipped or duplicated, and rdy must rise only after the 8th accepted beat.
- Pulse start at cycle 20 of CALC (ignored, result unchanged). Then assert rst_b=0 mid-CALC: rdy=1, send_output=0, P=0 immediately. A following operation must compute correctly.
- Parameter sweep OP_W=16, BUS_W=4: 0x1234 × 0x0010 unsigned -> 0x00012340 over 8 beats; latency 8+16 = 24 cycles. Compare against a random reference model, 200 vectors, both modes.
